idecoder_queue: RTL and testbench

- Queued, registered successor to the combinational instruction decoder for the 16-bit simple RISC datapath.
- Accepts raw instruction words over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Decodes the FIFO head into a registered output bundle that the controller consumes over a second valid/ready handshake.
- Adds parametrised sign-extension width, illegal-instruction detection, flush and occupancy/error status.

---
 rtl/idecoder_queue_if.sv | 37 +++
 rtl/idecoder_queue.sv | 149 ++++++++++++++
 tb/tb_idecoder_queue.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/idecoder_queue_if.sv
// Handshake and decoded-bundle signals between the instruction source,
// the queued decoder and the controller that consumes the bundles.
interface idecoder_queue_if #(
    parameter int DATA_W = 16
);
    // Input handshake
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr;

    // Output handshake and decoded bundle
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        reg_sel;
    logic [2:0]        opcode;
    logic [1:0]        ALU_op;
    logic [1:0]        shift_op;
    logic [DATA_W-1:0] sximm5;
    logic [DATA_W-1:0] sximm8;
    logic [2:0]        r_addr;
    logic [2:0]        w_addr;
    logic              illegal;

    // Environment side: offers words, consumes bundles, selects register fields
    modport master (
        output in_valid, instr, out_ready, reg_sel,
        input  in_ready, out_valid, opcode, ALU_op, shift_op,
               sximm5, sximm8, r_addr, w_addr, illegal
    );

    // Decoder side
    modport slave (
        input  in_valid, instr, out_ready, reg_sel,
        output in_ready, out_valid, opcode, ALU_op, shift_op,
               sximm5, sximm8, r_addr, w_addr, illegal
    );
endinterface

// File: rtl/idecoder_queue.sv
// Queued instruction decoder: raw words are buffered in a DEPTH-entry FIFO,
// the head is decoded into a registered bundle held until the consumer takes
// it. Illegal encodings flow through but are flagged and counted.
module idecoder_queue #(
    parameter int DEPTH  = 4,   // power of two, >= 2
    parameter int DATA_W = 16   // >= 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    idecoder_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err,
    output logic [7:0]             illegal_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage and pointers
    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Registered decode bundle
    logic              out_valid_q;
    logic [2:0]        opcode_q;
    logic [1:0]        alu_op_q;
    logic [1:0]        shift_op_q;
    logic [DATA_W-1:0] sximm5_q;
    logic [DATA_W-1:0] sximm8_q;
    logic [2:0]        rn_q;
    logic [2:0]        rd_q;
    logic [2:0]        rm_q;
    logic              illegal_q;

    logic        full;
    logic        push;
    logic        pop;
    logic        consume_illegal;
    logic [15:0] head;
    logic        head_legal;
    logic [2:0]  sel_field;

    // MOV imm / MOV reg under opcode 110, every ALU op under opcode 101
    function automatic logic is_legal(input logic [15:0] w);
        return (w[15:13] == 3'b110 && (w[12:11] == 2'b10 || w[12:11] == 2'b00))
            || (w[15:13] == 3'b101);
    endfunction

    // No bypass when full: a same-cycle pop does not open the input
    assign full            = (count == CNT_W'(DEPTH));
    assign bus.in_ready    = !full;
    assign push            = bus.in_valid && !full;
    assign pop             = (!out_valid_q || bus.out_ready) && (count != '0);
    assign consume_illegal = out_valid_q && bus.out_ready && illegal_q;
    assign head            = mem[rd_ptr];
    assign head_legal      = is_legal(head);

    // FIFO data write; contents need no reset because count gates every read
    // NOTE: storage arrays are left out of reset so they map onto plain RAM/regfile cells; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= bus.instr;
        end
    end

    // FIFO pointers, occupancy and the registered output stage
    // NOTE: every register here uses <= so all updates see the pre-edge values of count/out_valid_q, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            alu_op_q    <= '0;
            shift_op_q  <= '0;
            sximm5_q    <= '0;
            sximm8_q    <= '0;
            rn_q        <= '0;
            rd_q        <= '0;
            rm_q        <= '0;
            illegal_q   <= 1'b0;
            err         <= 1'b0;
            illegal_cnt <= '0;
        end else if (flush) begin
            // Flush wins over push and pop; error status survives it
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                out_valid_q <= 1'b1;
                opcode_q    <= head[15:13];
                alu_op_q    <= head[12:11];
                shift_op_q  <= head[4:3];
                sximm5_q    <= {{(DATA_W-5){head[4]}}, head[4:0]};
                sximm8_q    <= {{(DATA_W-8){head[7]}}, head[7:0]};
                rn_q        <= head[10:8];
                rd_q        <= head[7:5];
                rm_q        <= head[2:0];
                illegal_q   <= !head_legal;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (consume_illegal) begin
                err <= 1'b1;
                if (illegal_cnt != 8'hFF) begin
                    illegal_cnt <= illegal_cnt + 8'd1;
                end
            end
        end
    end

    // Register field select from the held bundle (only combinational output path)
    // NOTE: sel_field gets a default before the case so no latch is inferred.
    always_comb begin
        sel_field = 3'b000;
        case (bus.reg_sel)
            2'b10:   sel_field = rn_q;
            2'b01:   sel_field = rd_q;
            2'b00:   sel_field = rm_q;
            default: sel_field = 3'b000;
        endcase
    end

    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = opcode_q;
    assign bus.ALU_op    = alu_op_q;
    assign bus.shift_op  = shift_op_q;
    assign bus.sximm5    = sximm5_q;
    assign bus.sximm8    = sximm8_q;
    assign bus.illegal   = illegal_q;
    assign bus.r_addr    = sel_field;
    assign bus.w_addr    = sel_field;
endmodule

// File: tb/tb_idecoder_queue.sv
// Directed bench for idecoder_queue: decode fields, back-pressure, in-order
// drain, illegal counting with saturation, flush, wide sign extension and
// asynchronous reset.
module tb_idecoder_queue;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    idecoder_queue_if #(.DATA_W(16)) bus16 ();
    idecoder_queue_if #(.DATA_W(32)) bus32 ();

    logic [2:0] count16;
    logic       err16;
    logic [7:0] illegal_cnt16;
    logic [2:0] count32;
    logic       err32;
    logic [7:0] illegal_cnt32;

    int checks   = 0;
    int failures = 0;

    idecoder_queue #(.DEPTH(4), .DATA_W(16)) u_dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus16.slave),
        .count       (count16),
        .err         (err16),
        .illegal_cnt (illegal_cnt16)
    );

    idecoder_queue #(.DEPTH(4), .DATA_W(32)) u_dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus32.slave),
        .count       (count32),
        .err         (err32),
        .illegal_cnt (illegal_cnt32)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for exactly one edge on the 16-bit instance
    task automatic push16(input logic [15:0] w);
        bus16.in_valid = 1'b1;
        bus16.instr    = w;
        tick();
        bus16.in_valid = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.instr     = '0;
        bus16.out_ready = 1'b0;
        bus16.reg_sel   = 2'b10;
        bus32.in_valid  = 1'b0;
        bus32.instr     = '0;
        bus32.out_ready = 1'b0;
        bus32.reg_sel   = 2'b10;

        // ---- reset state ----
        #12;
        check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        check("rst_count", 32'(count16), 32'd0);
        check("rst_in_ready", 32'(bus16.in_ready), 32'd1);
        check("rst_err", 32'(err16), 32'd0);
        check("rst_illegal_cnt", 32'(illegal_cnt16), 32'd0);
        check("rst_sximm8", 32'(bus16.sximm8), 32'd0);
        rst_n = 1'b1;

        // ---- MOV R1,#7: one-edge latency from push to bundle ----
        bus16.out_ready = 1'b1;
        push16(16'b1101000100000111);
        check("mov_count_after_push", 32'(count16), 32'd1);
        check("mov_valid_after_push", 32'(bus16.out_valid), 32'd0);
        tick();
        check("mov_out_valid", 32'(bus16.out_valid), 32'd1);
        check("mov_opcode", 32'(bus16.opcode), 32'b110);
        check("mov_alu_op", 32'(bus16.ALU_op), 32'b10);
        check("mov_sximm8", 32'(bus16.sximm8), 32'h0007);
        check("mov_r_addr", 32'(bus16.r_addr), 32'b001);
        check("mov_illegal", 32'(bus16.illegal), 32'd0);
        check("mov_count_after_load", 32'(count16), 32'd0);

        // ---- ADD R3,R1,R3: field selects ----
        push16(16'b1010000101100011);
        check("add_prev_consumed", 32'(bus16.out_valid), 32'd0);
        tick();
        check("add_out_valid", 32'(bus16.out_valid), 32'd1);
        check("add_opcode", 32'(bus16.opcode), 32'b101);
        check("add_alu_op", 32'(bus16.ALU_op), 32'b00);
        check("add_shift_op", 32'(bus16.shift_op), 32'b00);
        check("add_illegal", 32'(bus16.illegal), 32'd0);
        bus16.reg_sel = 2'b10; #1;
        check("add_rn", 32'(bus16.r_addr), 32'b001);
        bus16.reg_sel = 2'b01; #1;
        check("add_rd", 32'(bus16.r_addr), 32'b011);
        check("add_rd_w", 32'(bus16.w_addr), 32'b011);
        bus16.reg_sel = 2'b00; #1;
        check("add_rm", 32'(bus16.r_addr), 32'b011);
        bus16.reg_sel = 2'b11; #1;
        check("add_sel11", 32'(bus16.w_addr), 32'b000);
        bus16.reg_sel = 2'b10;

        // ---- negative imm8 ----
        push16(16'b1101000010000000);
        tick();
        check("neg_sximm8", 32'(bus16.sximm8), 32'h0000FF80);
        check("neg_sximm5", 32'(bus16.sximm5), 32'h00000000);
        tick();
        check("neg_consumed", 32'(bus16.out_valid), 32'd0);

        // ---- back-pressure: five words accepted, sixth refused ----
        bus16.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push16(16'hD000 | 16'(i));
        end
        check("full_count", 32'(count16), 32'd4);
        check("full_in_ready", 32'(bus16.in_ready), 32'd0);
        check("full_head", 32'(bus16.sximm8), 32'h0001);
        bus16.in_valid = 1'b1;
        bus16.instr    = 16'hD006;
        tick();
        check("refused_count", 32'(count16), 32'd4);
        check("held_stable", 32'(bus16.sximm8), 32'h0001);

        // Drain in order; the refused word enters once space opens
        bus16.out_ready = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            tick();
            check($sformatf("drain_%0d", k), 32'(bus16.sximm8), 32'(k));
            if (k == 2) check("drain_no_passthrough", 32'(count16), 32'd3);
            if (k == 3) begin
                check("drain_refill_count", 32'(count16), 32'd3);
                bus16.in_valid = 1'b0;
            end
        end
        check("drain_empty", 32'(count16), 32'd0);
        tick();
        check("drain_done", 32'(bus16.out_valid), 32'd0);

        // ---- illegal word: flag, sticky err, counter ----
        push16(16'hE000);
        tick();
        check("ill_flag", 32'(bus16.illegal), 32'd1);
        check("ill_err_before", 32'(err16), 32'd0);
        tick();
        check("ill_err", 32'(err16), 32'd1);
        check("ill_cnt1", 32'(illegal_cnt16), 32'd1);

        // Stream illegal words: n edges from idle consume n-2 words
        bus16.in_valid = 1'b1;
        bus16.instr    = 16'hE000;
        repeat (100) tick();
        check("ill_cnt99", 32'(illegal_cnt16), 32'd99);
        repeat (300) tick();
        bus16.in_valid = 1'b0;
        repeat (3) tick();
        check("ill_cnt_sat", 32'(illegal_cnt16), 32'd255);
        check("ill_drained", 32'(bus16.out_valid), 32'd0);

        // ---- flush with a same-cycle push ----
        bus16.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push16(16'hD010 | 16'(i));
        end
        check("flush_pre_count", 32'(count16), 32'd3);
        flush          = 1'b1;
        bus16.in_valid = 1'b1;
        bus16.instr    = 16'hD01F;
        tick();
        flush          = 1'b0;
        bus16.in_valid = 1'b0;
        check("flush_count", 32'(count16), 32'd0);
        check("flush_out_valid", 32'(bus16.out_valid), 32'd0);
        check("flush_err", 32'(err16), 32'd1);
        check("flush_cnt", 32'(illegal_cnt16), 32'd255);
        tick();
        check("flush_push_ignored", 32'(bus16.out_valid), 32'd0);

        // ---- DATA_W=32 sign extension ----
        bus32.out_ready = 1'b1;
        bus32.in_valid  = 1'b1;
        bus32.instr     = 16'hD010;
        tick();
        bus32.in_valid  = 1'b0;
        tick();
        check("w32_valid", 32'(bus32.out_valid), 32'd1);
        check("w32_sximm5", bus32.sximm5, 32'hFFFFFFF0);
        check("w32_sximm8", bus32.sximm8, 32'h00000010);

        // ---- async reset mid-transfer ----
        bus16.out_ready = 1'b0;
        push16(16'hD0AA);
        push16(16'hD0BB);
        check("pre_rst_count", 32'(count16), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus16.out_valid), 32'd0);
        check("arst_count", 32'(count16), 32'd0);
        check("arst_sximm8", 32'(bus16.sximm8), 32'd0);
        check("arst_opcode", 32'(bus16.opcode), 32'd0);
        check("arst_err", 32'(err16), 32'd0);
        check("arst_cnt", 32'(illegal_cnt16), 32'd0);
        check("arst_w32_sximm5", bus32.sximm5, 32'd0);
        check("arst_w32_valid", 32'(bus32.out_valid), 32'd0);
        #1;
        rst_n = 1'b1;
        bus16.out_ready = 1'b1;
        tick();
        tick();
        check("post_rst_discarded", 32'(bus16.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
